mult_control: RTL and testbench



---
 rtl/mult_pkg.sv | 34 +++
 rtl/booth_decoder.sv | 37 +++
 rtl/mult_control.sv | 99 +++++++++
 tb/tb_mult_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the radix-4 Booth multiplier control
//
// Purpose: FSM state encoding, Booth operation encoding, default iteration
// count and the Booth window classifier shared by mult_control and booth_decoder.
package mult_pkg;

  localparam int DEFAULT_ITERATIONS = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    NONE,
    ADD_M,
    ADD_2M,
    SUB_M,
    SUB_2M
  } booth_op_t;

  // Window is {q[i+1], q[i], q[i-1]}; the digit is -2*q[i+1] + q[i] + q[i-1].
  function automatic booth_op_t booth_op(input logic [2:0] window);
    case (window)
      3'b001, 3'b010: return ADD_M;
      3'b011:         return ADD_2M;
      3'b100:         return SUB_2M;
      3'b101, 3'b110: return SUB_M;
      default:        return NONE;
    endcase
  endfunction

endpackage

// File: rtl/booth_decoder.sv
// rtl/booth_decoder.sv - combinational Booth window to datapath strobe decode
//
// Purpose: maps a 3-bit Booth window to add/sub/multiplicand-doubling strobes.
// Ports:
//   data_in_i      3-bit Booth window {q[i+1], q[i], q[i-1]}
//   add_o          add the (possibly doubled) multiplicand
//   sub_o          subtract the (possibly doubled) multiplicand
//   shift_mcand_o  use 2x multiplicand
module booth_decoder
  import mult_pkg::*;
(
  input  logic [2:0] data_in_i,
  output logic       add_o,
  output logic       sub_o,
  output logic       shift_mcand_o
);

  always_comb begin
    add_o         = 1'b0;
    sub_o         = 1'b0;
    shift_mcand_o = 1'b0;
    case (booth_op(data_in_i))
      ADD_M:  add_o = 1'b1;
      ADD_2M: begin
        add_o         = 1'b1;
        shift_mcand_o = 1'b1;
      end
      SUB_M:  sub_o = 1'b1;
      SUB_2M: begin
        sub_o         = 1'b1;
        shift_mcand_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_control.sv
// rtl/mult_control.sv - control FSM for a radix-4 Booth sequential multiplier
//
// Purpose: sequences ITERATIONS Booth steps, decoding the multiplier window
// each RUN cycle into datapath strobes and requesting a 2-bit product shift.
// Optional feature macro: MULT_CONTROL_COUNT_OUT_EN adds count/busy outputs.
// Ports:
//   clock              rising-edge clock
//   resetn             synchronous active-low reset
//   start              begin (or restart) a multiplication
//   data_in            Booth window from the product/multiplier register
//   add, sub           add/subtract multiplicand (Mealy on data_in, RUN only)
//   shiftMultiplicand  use 2x multiplicand for this add/sub
//   shiftProduct       arithmetic right-shift product by 2 this cycle
//   count, busy        (macro only) iteration counter and RUN indicator
//   ready              result valid, held until the next start
module mult_control
  import mult_pkg::*;
#(
  parameter int ITERATIONS = DEFAULT_ITERATIONS
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              start,
  input  logic [2:0]                        data_in,
  output logic                              add,
  output logic                              sub,
  output logic                              shiftMultiplicand,
  output logic                              shiftProduct,
`ifdef MULT_CONTROL_COUNT_OUT_EN
  output logic [$clog2(ITERATIONS+1)-1:0]   count,
  output logic                              busy,
`endif
  output logic                              ready
);

  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             shift_q;

  logic dec_add, dec_sub, dec_shift;

  booth_decoder u_booth_decoder (
    .data_in_i     (data_in),
    .add_o         (dec_add),
    .sub_o         (dec_sub),
    .shift_mcand_o (dec_shift)
  );

  // ready_q and shift_q are registered alongside the state so they are
  // glitch-free state decodes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      shift_q <= 1'b0;
    end else if (start) begin
      // start restarts from any state, including mid-RUN
      state_q <= RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      shift_q <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            shift_q <= 1'b0;
          end
        end
        IDLE, DONE: ;
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          shift_q <= 1'b0;
        end
      endcase
    end
  end

  // Booth strobes are Mealy on data_in but only while iterating.
  assign add               = shift_q & dec_add;
  assign sub               = shift_q & dec_sub;
  assign shiftMultiplicand = shift_q & dec_shift;
  assign shiftProduct      = shift_q;
  assign ready             = ready_q;

`ifdef MULT_CONTROL_COUNT_OUT_EN
  assign count = cnt_q;
  assign busy  = (state_q == RUN);
`endif

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - self-checking bench for mult_control
module tb_mult_control;

  localparam int ITER = 16;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [2:0] data_in;
  logic       add, sub, shiftMultiplicand, shiftProduct, ready;
`ifdef MULT_CONTROL_COUNT_OUT_EN
  logic [$clog2(ITER+1)-1:0] count;
  logic                      busy;
`endif

  mult_control #(.ITERATIONS(ITER)) dut (
    .clock             (clock),
    .resetn            (resetn),
    .start             (start),
    .data_in           (data_in),
    .add               (add),
    .sub               (sub),
    .shiftMultiplicand (shiftMultiplicand),
    .shiftProduct      (shiftProduct),
`ifdef MULT_CONTROL_COUNT_OUT_EN
    .count             (count),
    .busy              (busy),
`endif
    .ready             (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic add;
    logic sub;
    logic sm;
    logic sp;
    logic rdy;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // reference model: 0 idle, 1 run, 2 done
  int m_state = 0;
  int m_cnt   = 0;

  function automatic logic [2:0] exp_dec(input logic [2:0] d);
    case (d)
      3'b001, 3'b010: return 3'b100;
      3'b011:         return 3'b101;
      3'b100:         return 3'b011;
      3'b101, 3'b110: return 3'b010;
      default:        return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %b expected %b", phase, tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, push the expected
  // outputs, compare after settling, then advance the model at the rising edge.
  task automatic cycle(input logic st, input logic [2:0] d, input logic rn,
                       output logic sp_o, output logic rdy_o);
    exp_t e;
    exp_t got;
    logic [2:0] dec;
    start   = st;
    data_in = d;
    resetn  = rn;
    dec     = (m_state == 1) ? exp_dec(d) : 3'b000;
    e.add   = dec[2];
    e.sub   = dec[1];
    e.sm    = dec[0];
    e.sp    = (m_state == 1);
    e.rdy   = (m_state == 2);
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check("add", add, got.add);
    check("sub", sub, got.sub);
    check("shiftMultiplicand", shiftMultiplicand, got.sm);
    check("shiftProduct", shiftProduct, got.sp);
    check("ready", ready, got.rdy);
    check("add_sub_excl", add & sub, 1'b0);
    sp_o  = shiftProduct;
    rdy_o = ready;
    @(posedge clock);
    if (!rn) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (st) begin
      m_state = 1;
      m_cnt   = 0;
    end else if (m_state == 1) begin
      if (m_cnt == ITER - 1) m_state = 2;
      m_cnt++;
    end
    @(negedge clock);
  endtask

  // Counts observed shiftProduct cycles until ready appears (bounded).
  task automatic run_until_ready(input int exp_len);
    logic sp, rdy;
    int   runs = 0;
    logic seen = 1'b0;
    for (int g = 0; g < 40; g++) begin
      cycle(1'b0, 3'($urandom_range(0, 7)), 1'b1, sp, rdy);
      if (rdy) begin
        seen = 1'b1;
        break;
      end
      if (sp) runs++;
    end
    check("ready_seen", seen, 1'b1);
    check_int("run_len", runs, exp_len);
  endtask

  initial begin
    logic sp, rdy;
    int   runs;

    resetn  = 1'b0;
    start   = 1'b0;
    data_in = 3'b000;
    @(posedge clock);
    @(negedge clock);

    phase = "reset";
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b0, sp, rdy);
    cycle(1'b0, 3'b011, 1'b1, sp, rdy);
    check("idle_no_shift", sp, 1'b0);

    phase = "basic";
    cycle(1'b1, 3'b000, 1'b1, sp, rdy);
    runs = 0;
    for (int i = 0; i < ITER; i++) begin
      cycle(1'b0, 3'b000, 1'b1, sp, rdy);
      if (sp) runs++;
    end
    check_int("run_len", runs, 16);
    phase = "hold";
    for (int i = 0; i < 300; i++) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b1, sp, rdy);
    check("ready_held", rdy, 1'b1);

    phase = "sweep";
    cycle(1'b1, 3'b000, 1'b1, sp, rdy);
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), 1'b1, sp, rdy);
    cycle(1'b0, 3'b011, 1'b1, sp, rdy);
    cycle(1'b0, 3'b100, 1'b1, sp, rdy);
    run_until_ready(ITER - 10);

    phase = "reset_mid";
    cycle(1'b1, 3'b000, 1'b1, sp, rdy);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b1, sp, rdy);
    cycle(1'b1, 3'b011, 1'b0, sp, rdy);
    cycle(1'b0, 3'b011, 1'b1, sp, rdy);
    check("after_reset_shift", sp, 1'b0);
    check("after_reset_ready", rdy, 1'b0);
    cycle(1'b0, 3'b100, 1'b1, sp, rdy);
    cycle(1'b1, 3'b000, 1'b1, sp, rdy);
    run_until_ready(ITER);

    phase = "restart";
    cycle(1'b1, 3'b000, 1'b1, sp, rdy);
    for (int i = 0; i < 9; i++) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b1, sp, rdy);
    cycle(1'b1, 3'b110, 1'b1, sp, rdy);
    run_until_ready(ITER);

    phase = "start_in_done";
    cycle(1'b1, 3'b001, 1'b1, sp, rdy);
    check("ready_before", rdy, 1'b1);
    cycle(1'b0, 3'b001, 1'b1, sp, rdy);
    check("ready_dropped", rdy, 1'b0);
    run_until_ready(ITER - 1);

    phase = "held_start";
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'($urandom_range(0, 7)), 1'b1, sp, rdy);
    run_until_ready(ITER);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
